// File: rtl/rs_job_sequencer.sv
// Job-level controller for the Reed-Solomon decoder AFU: decodes HC_CONTROL,
// walks the input/output buffers chunk by chunk and posts a DSM status record.
module rs_job_sequencer #(
  parameter int CHUNK_LINES = 32,
  parameter int CL_ADDR_W   = 58
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ctl_valid,
  input  logic [31:0]          ctl_value,
  input  logic [63:0]          dsm_base,
  input  logic [63:0]          in_addr,
  input  logic [31:0]          in_size,
  input  logic [63:0]          out_addr,
  input  logic [31:0]          out_size,
  output logic                 rd_cmd_valid,
  input  logic                 rd_cmd_ready,
  output logic [CL_ADDR_W-1:0] rd_cmd_addr,
  output logic [7:0]           rd_cmd_lines,
  input  logic                 rd_done,
  output logic                 wr_cmd_valid,
  input  logic                 wr_cmd_ready,
  output logic [CL_ADDR_W-1:0] wr_cmd_addr,
  output logic [7:0]           wr_cmd_lines,
  input  logic                 wr_done,
  output logic                 dsm_valid,
  input  logic                 dsm_ready,
  output logic [CL_ADDR_W-1:0] dsm_addr,
  output logic [63:0]          dsm_data,
  output logic                 busy
);

  localparam logic [7:0]  CHUNK   = 8'(CHUNK_LINES);
  localparam logic [31:0] CHUNK32 = 32'(CHUNK_LINES);

  localparam logic [31:0] CTL_ASSERT_RST   = 32'h0;
  localparam logic [31:0] CTL_DEASSERT_RST = 32'h1;
  localparam logic [31:0] CTL_START        = 32'h3;
  localparam logic [31:0] CTL_STOP         = 32'h7;

  typedef enum logic [2:0] {
    S_DISABLED,
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_WR_ISSUE,
    S_WR_WAIT,
    S_DSM,
    S_DONE
  } state_t;

  state_t               state;
  logic [CL_ADDR_W-1:0] in_base;
  logic [CL_ADDR_W-1:0] out_base;
  logic [31:0]          in_lines;
  logic [31:0]          lines_done;
  logic [7:0]           chunk;
  logic                 abort;

  logic [31:0] start_in_lines;
  logic [31:0] start_out_lines;
  logic [7:0]  start_chunk;
  logic [31:0] next_done;
  logic [31:0] remain;
  logic [7:0]  next_chunk;

  // Line counts for a START in this cycle, and the chunk following the current one.
  always_comb begin
    start_in_lines  = 32'(({1'b0, in_size} + 33'd63) >> 6);
    start_out_lines = 32'(({1'b0, out_size} + 33'd63) >> 6);
    start_chunk     = (start_in_lines < CHUNK32) ? start_in_lines[7:0] : CHUNK;
    next_done       = lines_done + {24'h0, chunk};
    remain          = in_lines - next_done;
    next_chunk      = (remain < CHUNK32) ? remain[7:0] : CHUNK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_DISABLED;
      in_base      <= '0;
      out_base     <= '0;
      in_lines     <= '0;
      lines_done   <= '0;
      chunk        <= '0;
      abort        <= 1'b0;
      rd_cmd_valid <= 1'b0;
      rd_cmd_addr  <= '0;
      rd_cmd_lines <= '0;
      wr_cmd_valid <= 1'b0;
      wr_cmd_addr  <= '0;
      wr_cmd_lines <= '0;
      dsm_valid    <= 1'b0;
      dsm_addr     <= '0;
      dsm_data     <= '0;
      busy         <= 1'b0;
    end else if (ctl_valid && ctl_value == CTL_ASSERT_RST) begin
      // Soft reset abandons any in-flight job; engines drain on their own.
      state        <= S_DISABLED;
      in_lines     <= '0;
      lines_done   <= '0;
      chunk        <= '0;
      abort        <= 1'b0;
      rd_cmd_valid <= 1'b0;
      rd_cmd_addr  <= '0;
      rd_cmd_lines <= '0;
      wr_cmd_valid <= 1'b0;
      wr_cmd_addr  <= '0;
      wr_cmd_lines <= '0;
      dsm_valid    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      if (ctl_valid && ctl_value == CTL_STOP && busy) begin
        abort <= 1'b1;
      end
      case (state)
        S_DISABLED: begin
          if (ctl_valid && ctl_value == CTL_DEASSERT_RST) begin
            state <= S_IDLE;
          end
        end
        S_IDLE, S_DONE: begin
          if (ctl_valid && ctl_value == CTL_START) begin
            in_base    <= CL_ADDR_W'(in_addr >> 6);
            out_base   <= CL_ADDR_W'(out_addr >> 6);
            dsm_addr   <= CL_ADDR_W'(dsm_base >> 6);
            in_lines   <= start_in_lines;
            lines_done <= '0;
            abort      <= 1'b0;
            busy       <= 1'b1;
            if (start_out_lines < start_in_lines) begin
              state     <= S_DSM;
              dsm_valid <= 1'b1;
              dsm_data  <= {8'h05, 24'h0, 32'h0};
            end else if (start_in_lines == 32'h0) begin
              state     <= S_DSM;
              dsm_valid <= 1'b1;
              dsm_data  <= {8'h01, 24'h0, 32'h0};
            end else begin
              state        <= S_RD_ISSUE;
              chunk        <= start_chunk;
              rd_cmd_valid <= 1'b1;
              rd_cmd_addr  <= CL_ADDR_W'(in_addr >> 6);
              rd_cmd_lines <= start_chunk;
            end
          end
        end
        S_RD_ISSUE: begin
          if (rd_cmd_ready) begin
            rd_cmd_valid <= 1'b0;
            state        <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (rd_done) begin
            state        <= S_WR_ISSUE;
            wr_cmd_valid <= 1'b1;
            wr_cmd_addr  <= out_base + CL_ADDR_W'(lines_done);
            wr_cmd_lines <= chunk;
          end
        end
        S_WR_ISSUE: begin
          if (wr_cmd_ready) begin
            wr_cmd_valid <= 1'b0;
            state        <= S_WR_WAIT;
          end
        end
        S_WR_WAIT: begin
          // Chunk boundary: the only point where a pending STOP is honoured.
          if (wr_done) begin
            lines_done <= next_done;
            if (next_done == in_lines || abort) begin
              state     <= S_DSM;
              dsm_valid <= 1'b1;
              dsm_data  <= {6'h0, abort, 1'b1, 24'h0, next_done};
            end else begin
              state        <= S_RD_ISSUE;
              chunk        <= next_chunk;
              rd_cmd_valid <= 1'b1;
              rd_cmd_addr  <= in_base + CL_ADDR_W'(next_done);
              rd_cmd_lines <= next_chunk;
            end
          end
        end
        S_DSM: begin
          if (dsm_ready) begin
            dsm_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_DONE;
          end
        end
        default: begin
          state <= S_DISABLED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs_job_sequencer.sv
// Directed bench for rs_job_sequencer: the bench plays the MMIO, rd/wr engines
// and DSM sink, with every expected command and status word worked out by hand.
module tb_rs_job_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ctl_valid;
  logic [31:0] ctl_value;
  logic [63:0] dsm_base;
  logic [63:0] in_addr;
  logic [31:0] in_size;
  logic [63:0] out_addr;
  logic [31:0] out_size;
  logic        rd_cmd_valid;
  logic        rd_cmd_ready;
  logic [57:0] rd_cmd_addr;
  logic [7:0]  rd_cmd_lines;
  logic        rd_done;
  logic        wr_cmd_valid;
  logic        wr_cmd_ready;
  logic [57:0] wr_cmd_addr;
  logic [7:0]  wr_cmd_lines;
  logic        wr_done;
  logic        dsm_valid;
  logic        dsm_ready;
  logic [57:0] dsm_addr;
  logic [63:0] dsm_data;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int cmd_seen = 0;

  always #5 clk = ~clk;

  rs_job_sequencer #(.CHUNK_LINES(32), .CL_ADDR_W(58)) dut (
    .clk(clk), .rst_n(rst_n),
    .ctl_valid(ctl_valid), .ctl_value(ctl_value),
    .dsm_base(dsm_base),
    .in_addr(in_addr), .in_size(in_size),
    .out_addr(out_addr), .out_size(out_size),
    .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
    .rd_cmd_addr(rd_cmd_addr), .rd_cmd_lines(rd_cmd_lines), .rd_done(rd_done),
    .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready),
    .wr_cmd_addr(wr_cmd_addr), .wr_cmd_lines(wr_cmd_lines), .wr_done(wr_done),
    .dsm_valid(dsm_valid), .dsm_ready(dsm_ready),
    .dsm_addr(dsm_addr), .dsm_data(dsm_data),
    .busy(busy)
  );

  // Counts cycles where any engine command is offered, to prove none were issued.
  always @(posedge clk) begin
    if (rd_cmd_valid || wr_cmd_valid) cmd_seen++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // All tasks below are entered and left at a falling clock edge.
  task automatic sendCtl(input logic [31:0] v);
    ctl_valid = 1'b1;
    ctl_value = v;
    @(negedge clk);
    ctl_valid = 1'b0;
    ctl_value = '0;
  endtask

  task automatic applyStimulus(input logic [63:0] ia, input logic [31:0] isz,
                               input logic [63:0] oa, input logic [31:0] osz,
                               input logic [63:0] db);
    in_addr  = ia;
    in_size  = isz;
    out_addr = oa;
    out_size = osz;
    dsm_base = db;
    sendCtl(32'h3);
  endtask

  task automatic pulseDone(input bit is_wr);
    if (is_wr) wr_done = 1'b1;
    else       rd_done = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
    wr_done = 1'b0;
  endtask

  task automatic expectCmd(input bit is_wr, input string tag, input logic [63:0] addr,
                           input logic [63:0] lines, input int hold, input bit stop_mid);
    int n = 0;
    bit stable = 1'b1;
    logic [63:0] a0, l0;
    while (!(is_wr ? wr_cmd_valid : rd_cmd_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_valid"}, 64'(is_wr ? wr_cmd_valid : rd_cmd_valid), 64'h1);
    if (!(is_wr ? wr_cmd_valid : rd_cmd_valid)) return;
    a0 = 64'(is_wr ? wr_cmd_addr : rd_cmd_addr);
    l0 = 64'(is_wr ? wr_cmd_lines : rd_cmd_lines);
    checkOutput({tag, "_addr"}, a0, addr);
    checkOutput({tag, "_lines"}, l0, lines);
    for (int i = 0; i < hold; i++) begin
      ctl_valid = stop_mid && (i == 0);
      ctl_value = (stop_mid && (i == 0)) ? 32'h7 : 32'h0;
      @(negedge clk);
      if (!(is_wr ? wr_cmd_valid : rd_cmd_valid) ||
          64'(is_wr ? wr_cmd_addr : rd_cmd_addr) != a0 ||
          64'(is_wr ? wr_cmd_lines : rd_cmd_lines) != l0) stable = 1'b0;
    end
    ctl_valid = 1'b0;
    ctl_value = '0;
    if (hold > 0) checkOutput({tag, "_stable"}, 64'(stable), 64'h1);
    if (is_wr) wr_cmd_ready = 1'b1;
    else       rd_cmd_ready = 1'b1;
    @(negedge clk);
    rd_cmd_ready = 1'b0;
    wr_cmd_ready = 1'b0;
    checkOutput({tag, "_drop"}, 64'(is_wr ? wr_cmd_valid : rd_cmd_valid), 64'h0);
  endtask

  task automatic runChunk(input string tag, input logic [63:0] icl, input logic [63:0] ocl,
                          input logic [63:0] lines);
    expectCmd(1'b0, {tag, "_rd"}, icl, lines, 0, 1'b0);
    pulseDone(1'b0);
    checkOutput({tag, "_wr_next"}, 64'(wr_cmd_valid), 64'h1);
    expectCmd(1'b1, {tag, "_wr"}, ocl, lines, 0, 1'b0);
    pulseDone(1'b1);
  endtask

  task automatic expectDsm(input string tag, input logic [63:0] data, input logic [63:0] addr);
    int n = 0;
    while (!dsm_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_dsm_valid"}, 64'(dsm_valid), 64'h1);
    checkOutput({tag, "_dsm_data"}, dsm_data, data);
    checkOutput({tag, "_dsm_addr"}, 64'(dsm_addr), addr);
    dsm_ready = 1'b1;
    @(negedge clk);
    dsm_ready = 1'b0;
    checkOutput({tag, "_idle"}, {62'h0, dsm_valid, busy}, 64'h0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seen0;
    rst_n = 1'b0;
    ctl_valid = 1'b0; ctl_value = '0;
    dsm_base = '0; in_addr = '0; in_size = '0; out_addr = '0; out_size = '0;
    rd_cmd_ready = 1'b0; wr_cmd_ready = 1'b0;
    rd_done = 1'b0; wr_done = 1'b0; dsm_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    checkOutput("reset_flags", {60'h0, rd_cmd_valid, wr_cmd_valid, dsm_valid, busy}, 64'h0);
    checkOutput("reset_rd_addr", 64'(rd_cmd_addr), 64'h0);
    checkOutput("reset_dsm_data", dsm_data, 64'h0);

    // START while disabled must be ignored.
    in_size = 32'd4096; out_size = 32'd4096;
    sendCtl(32'h3);
    checkOutput("start_disabled", {62'h0, rd_cmd_valid, busy}, 64'h0);
    sendCtl(32'h1);

    // Basic 64-line job with read-command backpressure and a stray wr_done.
    applyStimulus(64'h1000, 32'd4096, 64'h20000, 32'd4096, 64'h3000);
    checkOutput("t1_start_latency", 64'(rd_cmd_valid), 64'h1);
    checkOutput("t1_busy", 64'(busy), 64'h1);
    expectCmd(1'b0, "t1_rd0", 64'h40, 64'd32, 10, 1'b0);
    pulseDone(1'b1);
    checkOutput("t1_stray_wr_done", {61'h0, rd_cmd_valid, wr_cmd_valid, dsm_valid}, 64'h0);
    pulseDone(1'b0);
    checkOutput("t1_wr0_next", 64'(wr_cmd_valid), 64'h1);
    expectCmd(1'b1, "t1_wr0", 64'h800, 64'd32, 0, 1'b0);
    pulseDone(1'b1);
    checkOutput("t1_rd1_next", 64'(rd_cmd_valid), 64'h1);
    runChunk("t1_c1", 64'h60, 64'h820, 64'd32);
    expectDsm("t1", 64'h01000000_00000040, 64'hC0);

    // Restart from S_DONE: 2113 bytes -> 34 lines, tail chunk of 2.
    applyStimulus(64'h4000, 32'd2113, 64'h8000, 32'd4096, 64'h5000);
    runChunk("t2_c0", 64'h100, 64'h200, 64'd32);
    runChunk("t2_c1", 64'h120, 64'h220, 64'd2);
    expectDsm("t2", 64'h01000000_00000022, 64'h140);

    // Output buffer too small: status error, no engine commands.
    seen0 = cmd_seen;
    applyStimulus(64'h4000, 32'd256, 64'h8000, 32'd128, 64'h5000);
    checkOutput("t3_dsm_latency", {62'h0, rd_cmd_valid, dsm_valid}, 64'h1);
    expectDsm("t3", 64'h05000000_00000000, 64'h140);
    checkOutput("t3_no_cmds", 64'(cmd_seen - seen0), 64'h0);

    // Empty job.
    seen0 = cmd_seen;
    applyStimulus(64'h4000, 32'd0, 64'h8000, 32'd0, 64'h5000);
    expectDsm("t_empty", 64'h01000000_00000000, 64'h140);
    checkOutput("t_empty_no_cmds", 64'(cmd_seen - seen0), 64'h0);

    // STOP while the second read command is held off: 96-line job ends at 64.
    applyStimulus(64'h4000, 32'd6144, 64'h8000, 32'd6144, 64'h5000);
    runChunk("t4_c0", 64'h100, 64'h200, 64'd32);
    expectCmd(1'b0, "t4_rd1", 64'h120, 64'd32, 4, 1'b1);
    pulseDone(1'b0);
    expectCmd(1'b1, "t4_wr1", 64'h220, 64'd32, 0, 1'b0);
    pulseDone(1'b1);
    checkOutput("t4_abort_boundary", {62'h0, rd_cmd_valid, dsm_valid}, 64'h1);
    expectDsm("t4", 64'h03000000_00000040, 64'h140);

    // ASSERT_RST during S_WR_WAIT: back to disabled, no DSM write, late done ignored.
    applyStimulus(64'h4000, 32'd4096, 64'h8000, 32'd4096, 64'h5000);
    expectCmd(1'b0, "t5_rd0", 64'h100, 64'd32, 0, 1'b0);
    pulseDone(1'b0);
    expectCmd(1'b1, "t5_wr0", 64'h200, 64'd32, 0, 1'b0);
    sendCtl(32'h0);
    checkOutput("t5_soft_reset", {61'h0, rd_cmd_valid, wr_cmd_valid, busy}, 64'h0);
    pulseDone(1'b1);
    repeat (3) @(negedge clk);
    checkOutput("t5_no_dsm", {62'h0, dsm_valid, rd_cmd_valid}, 64'h0);
    sendCtl(32'h3);
    checkOutput("t5_start_disabled", {62'h0, rd_cmd_valid, busy}, 64'h0);
    sendCtl(32'h1);
    applyStimulus(64'h4000, 32'd4096, 64'h8000, 32'd4096, 64'h5000);
    expectCmd(1'b0, "t5_restart_rd", 64'h100, 64'd32, 0, 1'b0);
    pulseDone(1'b0);

    // Asynchronous rst_n mid-job while a write command is pending.
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_async_flags", {60'h0, rd_cmd_valid, wr_cmd_valid, dsm_valid, busy}, 64'h0);
    checkOutput("t6_async_payload", {6'h0, wr_cmd_addr}, 64'h0);
    checkOutput("t6_async_lines", {48'h0, rd_cmd_lines, wr_cmd_lines}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("t6_after_reset", {62'h0, wr_cmd_valid, busy}, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rs_job_sequencer.md
# rs_job_sequencer

Job-level controller for the Reed-Solomon decoder AFU. It owns the HardCloud control protocol: it latches the HC_CONTROL write, the DSM base and the input/output buffer descriptors. It then sequences the read engine and the write engine chunk by chunk over the buffers. On completion it posts a status record to the DSM. It sits between the MMIO decode logic and the rd/wr engines, and is the only issuer of their commands.

## Interface
- CHUNK_LINES, 32: maximum cache lines per rd/wr command (1..255)
- CL_ADDR_W, 58: cache-line address width (byte address >> 6)
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- ctl_valid  in  1  one-cycle pulse: HC_CONTROL written
- ctl_value  in  32  written control word
- dsm_base  in  64  DSM byte base address, sampled at START
- in_addr, in_size  in  64, 32  input buffer: byte address (64B aligned), byte size
- out_addr, out_size  in  64, 32  output buffer: byte address, byte size
- rd_cmd_valid  out  1  read command valid
- rd_cmd_ready  in  1  read engine accepts
- rd_cmd_addr  out  CL_ADDR_W  first cache line of the chunk
- rd_cmd_lines  out  8  line count, 1..CHUNK_LINES
- rd_done  in  1  pulse: last line of the current read chunk delivered to decoder
- wr_cmd_valid / wr_cmd_ready / wr_cmd_addr / wr_cmd_lines  out/in/out/out  1/1/CL_ADDR_W/8  same as the read side, for the output buffer
- wr_done  in  1  pulse: all writes of the current chunk acknowledged
- dsm_valid  out  1  DSM status write request
- dsm_ready  in  1  accepted
- dsm_addr  out  CL_ADDR_W  dsm_base >> 6
- dsm_data  out  64  {status[7:0], 24'h0, lines_done[31:0]}
- busy  out  1  state not in S_DISABLED/S_IDLE

## Operation
- Control decode, only when ctl_valid: 0x0 ASSERT_RST -> S_DISABLED, counters cleared, no DSM write. 0x1 DEASSERT_RST -> S_IDLE if currently S_DISABLED, else ignored. 0x3 START -> accepted only in S_IDLE. 0x7 STOP -> sets the abort flag if busy. Any other value is ignored.
- On START: latch all descriptors. Set in_lines = ceil(in_size/64) and out_lines = ceil(out_size/64), 32-bit with no overflow (size < 2^32). Clear lines_done.
- If out_lines < in_lines, go to S_DSM with status error; no commands are issued. If in_lines == 0, go to S_DSM with status done and lines_done = 0.
- States: S_DISABLED, S_IDLE, S_RD_ISSUE, S_RD_WAIT, S_WR_ISSUE, S_WR_WAIT, S_DSM, S_DONE.
- S_RD_ISSUE: rd_cmd_valid = 1 with addr = (in_addr>>6) + lines_done and lines = min(in_lines - lines_done, CHUNK_LINES). On a valid & ready cycle, go to S_RD_WAIT.
- S_RD_WAIT: on rd_done, go to S_WR_ISSUE.
- S_WR_ISSUE: same chunk against (out_addr>>6) + lines_done. On handshake, go to S_WR_WAIT.
- S_WR_WAIT: on wr_done, lines_done += chunk.
  - lines_done == in_lines, or abort set -> S_DSM.
  - Otherwise -> S_RD_ISSUE.
- The abort flag takes effect only at a chunk boundary; an issued chunk always completes.
- S_DSM: dsm_valid = 1 until dsm_ready, then S_DONE. status bit0 = done (always 1), bit1 = aborted, bit2 = size error, bits 7:3 = 0.
- S_DONE: idle-equivalent. START restarts the job; busy = 0.
- Command payloads are held stable while valid = 1 and not ready. Valid never drops without a handshake, except on reset or ASSERT_RST.
- rd_done/wr_done outside the matching wait state are ignored.

## Timing
- Reset: state S_DISABLED. All valids, busy and lines_done = 0; all addr/lines/data outputs = 0.
- START in cycle N -> rd_cmd_valid asserted in N+1; the size check result is registered by N+1.
- Handshake in cycle N -> valid low in N+1.
- A done pulse in cycle N -> next valid asserted in N+1, so there is one bubble per stage transition.
- ASSERT_RST mid-job takes effect the next cycle. Outstanding engine traffic is the engines' responsibility; later done pulses are ignored.
- A ctl_valid in the same cycle as a handshake: the handshake completes, and the control action applies from the next cycle.
- Asynchronous rst_n assertion clears immediately; deassertion is synchronized by the caller.

## Test plan
- Basic: in_size = out_size = 4096 (64 lines), CHUNK_LINES = 32 -> rd(base,32), wr(32), rd(+32,32), wr(+32,32), then DSM data = 0x01000000_00000040.
- Partial line and tail chunk: in_size = 2113 -> 34 lines. Chunks of 32 then 2. DSM lines_done = 34.
- Size error: in_size = 256, out_size = 128 -> no rd/wr commands. DSM status = 0x05, lines_done = 0.
- STOP during the second rd_cmd wait of a 96-line job -> that chunk completes read and write, then DSM status = 0x03, lines_done = 64.
- Backpressure: rd_cmd_ready low for 10 cycles -> payload stable and valid held. A stray wr_done during S_RD_WAIT is ignored.
- Control sequencing: START while S_DISABLED is ignored. ASSERT_RST in S_WR_WAIT -> S_DISABLED and no DSM write. Async rst_n mid-job -> all outputs 0.
